// File: rtl/fifo_pkg.sv
// Shared constants, types and helpers for the FIFO controller and its pointer counters.
package fifo_pkg;

  localparam int DefaultAddrWidth = 3;

  // Widest pointer the Gray helper handles; callers truncate to their own width.
  localparam int GrayMaxWidth = 32;

  // Status flags grouped so the flag logic can be assembled in one place.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Binary to reflected Gray code. Zero-extended inputs give correct low bits.
  function automatic logic [GrayMaxWidth-1:0] bin2gray(input logic [GrayMaxWidth-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Occupancy threshold checks, unsigned.
  function automatic logic count_at_least(input logic [31:0] count, input logic [31:0] thr);
    return count >= thr;
  endfunction

  function automatic logic count_at_most(input logic [31:0] count, input logic [31:0] thr);
    return count <= thr;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Binary pointer counter with wrap bit and a Gray-coded copy of the registered value.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int AddrWidth = DefaultAddrWidth
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [AddrWidth:0] bin_o,
  output logic [AddrWidth:0] gray_o
);

  localparam logic [AddrWidth:0] PtrOne = 1;

  logic [AddrWidth:0] bin_reg;
  logic [AddrWidth:0] bin_next;

  // Next pointer value: natural wrap modulo 2**(AddrWidth+1).
  always_comb begin
    bin_next = bin_reg + PtrOne;
  end

  // Reset and clear both return the pointer to zero; clear beats increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      bin_reg <= '0;
    end else if (inc_i) begin
      bin_reg <= bin_next;
    end
  end

  assign bin_o  = bin_reg;
  assign gray_o = (AddrWidth+1)'(bin2gray(GrayMaxWidth'(bin_reg)));

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller: handshake arbitration, RAM address/enable
// generation and occupancy flags derived from two pointer counters.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int AddrWidth      = DefaultAddrWidth,
  parameter int AlmostFullThr  = 6,
  parameter int AlmostEmptyThr = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic                 rd_ready_i,
  output logic                 rd_valid_o,
  output logic                 wr_en_o,
  output logic [AddrWidth-1:0] wr_addr_o,
  output logic                 rd_en_o,
  output logic [AddrWidth-1:0] rd_addr_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic [AddrWidth:0]   count_o,
  output logic [AddrWidth:0]   wr_ptr_gray_o,
  output logic [AddrWidth:0]   rd_ptr_gray_o
);

  localparam int WrSide = 0;
  localparam int RdSide = 1;

  logic [AddrWidth:0] ptr_bin  [2];
  logic [AddrWidth:0] ptr_gray [2];
  logic               ptr_inc  [2];

  logic               wr_acc;
  logic               rd_acc;
  logic [AddrWidth:0] count;
  fifo_flags_t        flags;

  // One counter per side; side 0 is the write pointer, side 1 the read pointer.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
    fifo_ptr #(
      .AddrWidth(AddrWidth)
    ) u_ptr (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (flush_i),
      .inc_i (ptr_inc[gi]),
      .bin_o (ptr_bin[gi]),
      .gray_o(ptr_gray[gi])
    );
  end

  // Flags and occupancy depend only on the registered pointers, never on this cycle's requests.
  always_comb begin
    count              = ptr_bin[WrSide] - ptr_bin[RdSide];
    flags.empty        = (ptr_bin[WrSide] == ptr_bin[RdSide]);
    flags.full         = (ptr_bin[WrSide][AddrWidth] != ptr_bin[RdSide][AddrWidth]) &&
                         (ptr_bin[WrSide][AddrWidth-1:0] == ptr_bin[RdSide][AddrWidth-1:0]);
    flags.almost_full  = count_at_least(32'(count), 32'(AlmostFullThr));
    flags.almost_empty = count_at_most(32'(count), 32'(AlmostEmptyThr));
  end

  // Accepts: reset and flush suppress both sides; full blocks writes, empty blocks reads,
  // so a simultaneous request on an empty FIFO never bypasses the RAM.
  always_comb begin
    wr_acc         = wr_valid_i && !flags.full  && !flush_i && !rst_i;
    rd_acc         = rd_ready_i && !flags.empty && !flush_i && !rst_i;
    ptr_inc[WrSide] = wr_acc;
    ptr_inc[RdSide] = rd_acc;
  end

  assign wr_en_o        = wr_acc;
  assign rd_en_o        = rd_acc;
  assign wr_addr_o      = ptr_bin[WrSide][AddrWidth-1:0];
  assign rd_addr_o      = ptr_bin[RdSide][AddrWidth-1:0];
  assign full_o         = flags.full;
  assign empty_o        = flags.empty;
  assign almost_full_o  = flags.almost_full;
  assign almost_empty_o = flags.almost_empty;
  assign wr_ready_o     = !flags.full;
  assign rd_valid_o     = !flags.empty;
  assign count_o        = count;
  assign wr_ptr_gray_o  = ptr_gray[WrSide];
  assign rd_ptr_gray_o  = ptr_gray[RdSide];

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl (depth 8): directed scenarios followed by
// random traffic, all checked every cycle against an occupancy/index model.
module tb_fifo_ctrl;

  localparam int Aw    = 3;
  localparam int Depth = 8;
  localparam int AfThr = 6;
  localparam int AeThr = 2;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          flush_i = 1'b0;
  logic          wr_valid_i = 1'b0;
  logic          rd_ready_i = 1'b0;
  logic          wr_ready_o, rd_valid_o, wr_en_o, rd_en_o;
  logic [Aw-1:0] wr_addr_o, rd_addr_o;
  logic          full_o, empty_o, almost_full_o, almost_empty_o;
  logic [Aw:0]   count_o, wr_ptr_gray_o, rd_ptr_gray_o;

  fifo_ctrl #(
    .AddrWidth(Aw), .AlmostFullThr(AfThr), .AlmostEmptyThr(AeThr)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .rd_ready_i(rd_ready_i), .rd_valid_o(rd_valid_o),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .count_o(count_o), .wr_ptr_gray_o(wr_ptr_gray_o), .rd_ptr_gray_o(rd_ptr_gray_o)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: occupancy plus total accepted writes/reads since the last clear.
  int occ  = 0;
  int widx = 0;
  int ridx = 0;
  int prev_wg = 0;
  int prev_rg = 0;
  bit wr_stepped = 0;
  bit rd_stepped = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int gray_of(input int idx);
    int b;
    b = idx % (2 * Depth);
    return b ^ (b / 2);
  endfunction

  function automatic int ones(input int v);
    int c = 0;
    for (int k = 0; k < 32; k++) c += (v >> k) & 1;
    return c;
  endfunction

  // One clock cycle: apply inputs, check all outputs mid-cycle, advance model and DUT.
  task automatic step(input bit wv, input bit rr, input bit fl, input bit rs);
    bit exp_w, exp_r;
    wr_valid_i = wv; rd_ready_i = rr; flush_i = fl; rst_i = rs;
    exp_w = wv && (occ < Depth) && !fl && !rs;
    exp_r = rr && (occ > 0) && !fl && !rs;
    @(negedge clk);
    chk("wr_en",     32'(wr_en_o),        32'(exp_w));
    chk("rd_en",     32'(rd_en_o),        32'(exp_r));
    chk("wr_addr",   32'(wr_addr_o),      32'(widx % Depth));
    chk("rd_addr",   32'(rd_addr_o),      32'(ridx % Depth));
    chk("count",     32'(count_o),        32'(occ));
    chk("full",      32'(full_o),         32'(occ == Depth));
    chk("empty",     32'(empty_o),        32'(occ == 0));
    chk("alm_full",  32'(almost_full_o),  32'(occ >= AfThr));
    chk("alm_empty", 32'(almost_empty_o), 32'(occ <= AeThr));
    chk("wr_ready",  32'(wr_ready_o),     32'(occ != Depth));
    chk("rd_valid",  32'(rd_valid_o),     32'(occ != 0));
    chk("wr_gray",   32'(wr_ptr_gray_o),  32'(gray_of(widx)));
    chk("rd_gray",   32'(rd_ptr_gray_o),  32'(gray_of(ridx)));
    if (wr_stepped) chk("wr_gray_1bit", 32'(ones(prev_wg ^ int'(wr_ptr_gray_o))), 32'd1);
    if (rd_stepped) chk("rd_gray_1bit", 32'(ones(prev_rg ^ int'(rd_ptr_gray_o))), 32'd1);
    prev_wg = int'(wr_ptr_gray_o);
    prev_rg = int'(rd_ptr_gray_o);
    if (fl || rs) begin
      occ = 0; widx = 0; ridx = 0;
      wr_stepped = 0; rd_stepped = 0;
    end else begin
      if (exp_w) begin widx++; occ++; end
      if (exp_r) begin ridx++; occ--; end
      wr_stepped = exp_w;
      rd_stepped = exp_r;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit wv, input bit rr);
    for (int k = 0; k < n; k++) step(wv, rr, 1'b0, 1'b0);
  endtask

  initial begin
    // Initial reset: DUT state is unknown before the first edge, so no checks here.
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);                       // post-reset state

    // Fill past full, then a fixed Gray value with wrap bit set.
    run(9, 1, 0);
    chk("fill_gray", 32'(wr_ptr_gray_o), 32'b1100);
    // Drain from full past empty.
    run(9, 0, 1);
    // Steady state with wrap-around.
    run(4, 1, 0);
    run(12, 1, 1);
    // Full plus both requests, then both again.
    run(4, 1, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("full_both_count", 32'(count_o), 32'd7);
    // Drain to empty, then both requests on empty.
    run(7, 0, 1);
    step(1, 1, 0, 0);
    chk("empty_both_count", 32'(count_o), 32'd1);
    // Flush at count 5 with a pending write.
    run(4, 1, 0);
    step(1, 0, 1, 0);
    chk("flush_empty", 32'(empty_o), 32'd1);
    // Reset at count 3 with a pending write.
    run(3, 1, 0);
    step(1, 0, 0, 1);
    chk("rst_count", 32'(count_o), 32'd0);
    run(2, 1, 0);
    chk("after_rst_wr_addr", 32'(wr_addr_o), 32'd2);

    // Random traffic with occasional flush/reset.
    for (int k = 0; k < 600; k++) begin
      step(($urandom % 4) != 0, ($urandom % 3) != 0,
           ($urandom % 64) == 0, ($urandom % 97) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
